// File: rtl/ddr_data_burst.sv
// ---------------------------------------------------------------------------
// ddr_data_burst
// DQ/DQS burst sequencer for a DDR data lane. It takes one-cycle start pulses
// from the CAS timing controller, runs a preamble, the burst itself and a
// one-cycle postamble, and drives the write strobe, the output enables and
// the write beat-pair register. On reads it captures dq_in one cycle late.
//
// Ports
//   CK_t        clock, rising edge
//   reset_n     asynchronous active-low reset
//   wr_rdy      write burst start pulse
//   rd_rdy      read burst start pulse
//   wr_pre      write preamble length (1..MAX_PRE, anything else -> 1)
//   rd_pre      read preamble length  (1..MAX_PRE, anything else -> 1)
//   bc4         1 = BC4 (2 burst cycles), 0 = BL8 (4 burst cycles)
//   wdata_in    write beat pair, taken while wdata_req is high
//   dq_in       read beat pair from the device
//   wdata_req   request for the next write beat pair
//   dq_out      registered write beat pair
//   dq_oe       DQ output enable
//   dqs_oe      DQS output enable
//   dqs_t       DQS strobe level
//   rdata       captured read beat pair
//   rdata_vld   rdata valid
//   busy        sequencer not idle
//   burst_done  pulse in the final burst cycle
//   err         pulse marking a rejected start request
// ---------------------------------------------------------------------------
module ddr_data_burst #(
    parameter int DQ_W    = 8,
    parameter int MAX_PRE = 2
) (
    input  logic              CK_t,
    input  logic              reset_n,
    input  logic              wr_rdy,
    input  logic              rd_rdy,
    input  logic [1:0]        wr_pre,
    input  logic [1:0]        rd_pre,
    input  logic              bc4,
    input  logic [2*DQ_W-1:0] wdata_in,
    input  logic [2*DQ_W-1:0] dq_in,
    output logic              wdata_req,
    output logic [2*DQ_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              dqs_oe,
    output logic              dqs_t,
    output logic [2*DQ_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              busy,
    output logic              burst_done,
    output logic              err
);

    localparam int CNT_MAX = (MAX_PRE > 4) ? MAX_PRE : 4;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {D_IDLE, D_PRE, D_BURST, D_POST} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     pre_last_q, pre_last_d;   // preamble length minus one
    logic              dir_wr_q, dir_wr_d;
    logic              bc4_q, bc4_d;
    logic              post_pend_q, post_pend_d; // pulse seen in D_POST
    logic              err_d;
    logic              seamless;
    logic              wreq_q;
    logic              dq_oe_q, dqs_oe_q, dqs_t_q, busy_q, burst_done_q, err_q;
    logic              rdata_vld_q;
    logic [2*DQ_W-1:0] dq_out_q, rdata_q;

    logic last_pre, last_burst, any_rdy, same_rdy, opp_rdy;

    // Index of the final burst cycle for a given burst-length selection.
    function automatic logic [CW-1:0] blen_last(input logic b);
        return b ? CW'(1) : CW'(3);
    endfunction

    // Out-of-range preamble lengths collapse to a single cycle.
    function automatic logic [CW-1:0] pre_last_of(input logic [1:0] p);
        logic [CW-1:0] r;
        r = '0;
        if (p != 2'd0 && int'(p) <= MAX_PRE)
            r = CW'(p - 2'd1);
        return r;
    endfunction

    assign last_pre   = (cnt_q == pre_last_q);
    assign last_burst = (cnt_q == blen_last(bc4_q));
    assign any_rdy    = wr_rdy | rd_rdy;
    assign same_rdy   = dir_wr_q ? wr_rdy : rd_rdy;
    assign opp_rdy    = dir_wr_q ? rd_rdy : wr_rdy;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_last_d  = pre_last_q;
        dir_wr_d    = dir_wr_q;
        bc4_d       = bc4_q;
        post_pend_d = 1'b0;
        err_d       = 1'b0;
        seamless    = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (wr_rdy && rd_rdy) begin
                    err_d = 1'b1;
                end else if (any_rdy) begin
                    state_d    = D_PRE;
                    cnt_d      = '0;
                    dir_wr_d   = wr_rdy;
                    bc4_d      = bc4;
                    pre_last_d = wr_rdy ? pre_last_of(wr_pre) : pre_last_of(rd_pre);
                end else if (post_pend_q) begin
                    // The pulse caught during D_POST did not persist: it is lost.
                    err_d = 1'b1;
                end
            end
            D_PRE: begin
                err_d = any_rdy;
                if (last_pre) begin
                    state_d = D_BURST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            D_BURST: begin
                if (last_burst) begin
                    err_d = opp_rdy;
                    if (same_rdy) begin
                        // Back-to-back burst: no preamble, burst length re-sampled.
                        seamless = 1'b1;
                        cnt_d    = '0;
                        bc4_d    = bc4;
                    end else begin
                        state_d = D_POST;
                        cnt_d   = '0;
                    end
                end else begin
                    err_d = any_rdy;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            D_POST: begin
                state_d     = D_IDLE;
                cnt_d       = '0;
                post_pend_d = any_rdy;
            end
            default: begin
                state_d = D_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers are loaded from the next-state values so that each
    // output lines up with the state it describes.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= D_IDLE;
            cnt_q        <= '0;
            pre_last_q   <= '0;
            dir_wr_q     <= 1'b0;
            bc4_q        <= 1'b0;
            post_pend_q  <= 1'b0;
            wreq_q       <= 1'b0;
            dq_oe_q      <= 1'b0;
            dqs_oe_q     <= 1'b0;
            dqs_t_q      <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_vld_q  <= 1'b0;
            dq_out_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pre_last_q   <= pre_last_d;
            dir_wr_q     <= dir_wr_d;
            bc4_q        <= bc4_d;
            post_pend_q  <= post_pend_d;
            err_q        <= err_d;
            busy_q       <= (state_d != D_IDLE);
            dq_oe_q      <= (state_d == D_BURST) && dir_wr_d;
            dqs_oe_q     <= (state_d != D_IDLE) && dir_wr_d;
            // Strobe starts high on the first burst cycle and toggles after.
            dqs_t_q      <= (state_d == D_BURST) && dir_wr_d && !cnt_d[0];
            burst_done_q <= (state_d == D_BURST) && (cnt_d == blen_last(bc4_d));
            wreq_q       <= dir_wr_d &&
                            (((state_d == D_PRE) && (cnt_d == pre_last_d)) ||
                             ((state_d == D_BURST) && (cnt_d != blen_last(bc4_d))));
            rdata_vld_q  <= (state_q == D_BURST) && !dir_wr_q;
            if ((state_q == D_BURST) && !dir_wr_q)
                rdata_q <= dq_in;
            if (wdata_req)
                dq_out_q <= wdata_in;
        end
    end

    // The final-cycle request of a seamless write depends on this cycle's
    // wr_rdy, so it cannot come from a register.
    assign wdata_req  = wreq_q | (seamless & dir_wr_q);
    assign dq_out     = dq_out_q;
    assign dq_oe      = dq_oe_q;
    assign dqs_oe     = dqs_oe_q;
    assign dqs_t      = dqs_t_q;
    assign rdata      = rdata_q;
    assign rdata_vld  = rdata_vld_q;
    assign busy       = busy_q;
    assign burst_done = burst_done_q;
    assign err        = err_q;

endmodule

// File: doc/ddr_data_burst.md
DDR_DATA_BURST -- requirements
Module: ddr_data_burst

Interface
REQ-001 Parameter: DQ_W, default 8, DQ lane width in bits.
REQ-002 Parameter: MAX_PRE, default 2, largest supported preamble length in cycles.
REQ-003 Port: CK_t  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: wr_rdy  input  1  one-cycle pulse that starts a write burst (from the CAS read/write timing controller).
REQ-006 Port: rd_rdy  input  1  one-cycle pulse that starts a read burst.
REQ-007 Port: wr_pre  input  2  write preamble length in cycles, legal values 1..MAX_PRE.
REQ-008 Port: rd_pre  input  2  read preamble length in cycles, legal values 1..MAX_PRE.
REQ-009 Port: bc4  input  1  selects burst length: 1 = BC4 (2 burst cycles), 0 = BL8 (4 burst cycles).
REQ-010 Port: wdata_in  input  2*DQ_W  write beat pair (rising beat in the low half), sampled when wdata_req=1.
REQ-011 Port: dq_in  input  2*DQ_W  read beat pair from the device.
REQ-012 Port: wdata_req  output  1  requests the next write beat pair.
REQ-013 Port: dq_out  output  2*DQ_W  registered write beat pair.
REQ-014 Port: dq_oe  output  1  DQ output enable.
REQ-015 Port: dqs_oe  output  1  DQS output enable.
REQ-016 Port: dqs_t  output  1  DQS strobe level.
REQ-017 Port: rdata  output  2*DQ_W  captured read beat pair.
REQ-018 Port: rdata_vld  output  1  rdata is valid this cycle.
REQ-019 Port: busy  output  1  state is not D_IDLE.
REQ-020 Port: burst_done  output  1  one-cycle pulse in the final burst cycle.
REQ-021 Port: err  output  1  one-cycle pulse marking a rejected request.

Function
REQ-022 FSM states: D_IDLE, D_PRE, D_BURST, D_POST. The direction bit (wr/rd) and the bc4 value are latched when a burst is accepted.
REQ-023 D_IDLE transitions:
- wr_rdy XOR rd_rdy -> D_PRE; clear the cycle counter.
- Both pulses asserted in the same cycle -> err=1 for one cycle; stay in D_IDLE.
REQ-024 D_PRE behaviour:
- Lasts wr_pre or rd_pre cycles, per the latched direction, then -> D_BURST.
- Write: dqs_oe=1, dqs_t=0, dq_oe=0.
- Read: dqs_oe=0.
REQ-025 D_BURST lasts 2 cycles (BC4) or 4 cycles (BL8).
- Write: dq_oe=1, dqs_oe=1, and dqs_t toggles every cycle, starting at 1.
- Read: each cycle, dq_in is registered to rdata with rdata_vld=1 on the following cycle (latency 1).
REQ-026 burst_done=1 in the last D_BURST cycle.
- Same-direction rdy pulse in that cycle -> stay in D_BURST (seamless burst, no preamble); the counter restarts and bc4 is re-latched.
- Otherwise -> D_POST.
REQ-027 D_POST lasts 1 cycle; dq_oe=0; dqs_oe stays 1 for writes with dqs_t=0; then -> D_IDLE. A rdy pulse in D_POST is accepted as if in D_IDLE on the next cycle only if it is still present; otherwise it is lost and err=1.
REQ-028 Any rdy pulse in D_PRE, in a non-final D_BURST cycle, or of the opposite direction in the final D_BURST cycle -> err=1; the pulse is ignored and the current burst is unaffected.
REQ-029 wdata_req=1 in the last D_PRE cycle of a write and in every write D_BURST cycle except the last. When a seamless write continues, wdata_req=1 in the last cycle as well. dq_out loads wdata_in on the edge that ends each wdata_req cycle.
REQ-030 An illegal preamble value (0, or greater than MAX_PRE) is treated as 1.
REQ-031 Counters are wide enough for max(MAX_PRE, 4) with no wrap; the counter clears on every state entry.

Reset
REQ-032 reset_n=0 forces, asynchronously:
- State D_IDLE.
- All enables, dqs_t, wdata_req, rdata_vld, busy, burst_done and err = 0.
- dq_out and rdata = 0.
REQ-033 Reset asserted mid-burst aborts the burst immediately. After release, the block waits in D_IDLE for a fresh rdy pulse.

Verification
REQ-034 BL8 write: wr_rdy at cycle 0, wr_pre=1, wdata_in=0x1100,0x3322,0x5544,0x7766 on successive requests -> D_PRE in cycle 1; dq_out 0x1100..0x7766 in cycles 2-5; dqs_t 1,0,1,0; burst_done in cycle 5; D_POST in cycle 6; busy low from cycle 7.
REQ-035 BC4 read: rd_rdy, rd_pre=2, dq_in=0xA5A5 then 0x5A5A -> dqs_oe=0 throughout; rdata_vld in cycles 4-5 with 0xA5A5, 0x5A5A.
REQ-036 Seamless: second wr_rdy in the final burst cycle of a BL8 write -> 8 consecutive dq_oe cycles, no D_PRE or D_POST between bursts, err=0.
REQ-037 Collisions:
- wr_rdy and rd_rdy together in D_IDLE -> err pulse, busy stays 0.
- rd_rdy in the final cycle of a write burst -> err pulse, write completes normally.
REQ-038 Reset: reset_n driven low in the 2nd burst cycle -> all outputs 0 within the same cycle; wr_rdy after release -> a normal burst.
REQ-039 Illegal preamble: wr_pre=0 -> 1-cycle preamble.
